button_event_queue: RTL and testbench

//  Upstream stage of the memory-mapped button poll at dmem address 7.
//  - Synchronises and debounces the four game buttons.
//  - Converts each debounced press into a 2-bit colour event and queues it in a small FIFO.
//  - Presents the queue head as the 32-bit word returned by lw 7; each completed poll pops one event.
//  - Colour encoding matches the LED driver: 00=red, 01=blue, 10=green, 11=yellow.

---
 rtl/button_event_queue_if.sv | 9 +
 rtl/button_event_queue.sv | 127 ++++++++++++
 tb/tb_button_event_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/button_event_queue_if.sv
// CPU-side poll bus for the button event queue at dmem address 7.
// Master drives poll; slave returns the read word on button_out.
interface button_event_queue_if;
  logic        poll;
  logic [31:0] button_out;

  modport master (output poll, input  button_out);
  modport slave  (input  poll, output button_out);
endinterface

// File: rtl/button_event_queue.sv
// Debounced button presses -> 2-bit colour FIFO read at dmem 7; pad->stable 2+DEBOUNCE_CYCLES, rise->button_out 1 cycle.
// No backpressure: full queue or simultaneous rises drop and set overflow; BUTTON_EVENT_COUNT_EN adds press counter.
module button_event_queue #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       red_button,
  input  logic                       blue_button,
  input  logic                       green_button,
  input  logic                       yellow_button,
  button_event_queue_if.slave        bus
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFO_DEPTH);

  // Bit index doubles as the colour code: 0=red, 1=blue, 2=green, 3=yellow.
  logic [3:0]       pads;
  logic [3:0]       sync1, sync2, stable, stable_d, armed;
  logic [1:0]       warm;
  logic [CNT_W-1:0] db_cnt [4];

  assign pads = {yellow_button, green_button, blue_button, red_button};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      armed    <= '0;
      warm     <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= pads;
      sync2    <= sync1;
      warm     <= {warm[0], 1'b1};
      stable_d <= stable;
      for (int i = 0; i < 4; i++) begin
        // A button only arms once its synced level is seen low, so one held through reset stays silent.
        if (warm[1] && !sync2[i]) armed[i] <= 1'b1;
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != {CNT_W{1'b1}}) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [3:0] rise;
  logic       push_req, multi;
  logic [1:0] push_col;

  assign rise  = stable & ~stable_d & armed;
  assign multi = (rise & (rise - 4'd1)) != 4'd0;

  always_comb begin
    push_col = 2'd0;
    push_req = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) begin
        push_col = 2'(i);
        push_req = 1'b1;
      end
    end
  end

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          poll_d, pop_stb, empty, full, do_pop, do_push, drop, ovf;

  assign pop_stb = poll_d & ~bus.poll;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop_stb & ~empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign do_push = push_req & (~full | do_pop);
  assign drop    = multi | (push_req & ~do_push);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      poll_d <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      poll_d <= bus.poll;
      if (do_push) begin
        mem[wr_ptr] <= push_col;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (drop)         ovf <= 1'b1;
      else if (pop_stb) ovf <= 1'b0;
    end
  end

  logic [2:0] head_bits;
  assign head_bits = empty ? 3'b000 : {1'b1, mem[rd_ptr]};

`ifdef BUTTON_EVENT_COUNT_EN
  logic [15:0] ev_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       ev_cnt <= '0;
    else if (do_push) ev_cnt <= ev_cnt + 16'd1;
  end

  assign bus.button_out = {ev_cnt, 12'd0, ovf, head_bits};
`else
  assign bus.button_out = {28'd0, ovf, head_bits};
`endif

endmodule

// File: tb/tb_button_event_queue.sv
// Bench for button_event_queue: directed scenarios plus random presses/polls checked against a queue model.
module tb_button_event_queue;
  localparam int DB    = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] pad;

  button_event_queue_if bus();

  button_event_queue #(.DEBOUNCE_CYCLES(DB), .CNT_W(4), .FIFO_DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .red_button    (pad[0]),
    .blue_button   (pad[1]),
    .green_button  (pad[2]),
    .yellow_button (pad[3]),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  q[$];
  logic        ovf;
  logic [15:0] evcnt;

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = '0;
    w[3] = ovf;
    if (q.size() != 0) begin
      w[2]   = 1'b1;
      w[1:0] = q[0];
    end
`ifdef BUTTON_EVENT_COUNT_EN
    w[31:16] = evcnt;
`endif
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_press(input logic [3:0] mask);
    logic [1:0] sel;
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) if (mask[i]) sel = 2'(i);
    if ($countones(mask) > 1) ovf = 1'b1;
    if (q.size() == DEPTH) begin
      ovf = 1'b1;
    end else begin
      q.push_back(sel);
      evcnt = evcnt + 16'd1;
    end
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    pad = mask;
    step(hold);
    model_press(mask);
    check("press", bus.button_out, model_word());
    pad = 4'b0000;
    step(12);
  endtask

  task automatic poll_read(input int len, input string tag);
    bus.poll = 1'b1;
    for (int i = 0; i < len; i++) begin
      step(1);
      check(tag, bus.button_out, model_word());
    end
    bus.poll = 1'b0;
    step(1);
    if (q.size() != 0) void'(q.pop_front());
    ovf = 1'b0;
    check({tag, "_after"}, bus.button_out, model_word());
  endtask

  initial begin
    reset    = 1'b0;
    pad      = 4'b0000;
    bus.poll = 1'b0;
    q.delete();
    ovf   = 1'b0;
    evcnt = '0;
    step(3);
    check("reset_state", bus.button_out, 32'h0);
    reset = 1'b1;
    step(4);

    // Single blue press, read over a 3-cycle poll window.
    press(4'b0010, 10);
    poll_read(3, "t1_poll");

    // Two-cycle glitch never survives debounce.
    pad = 4'b0010;
    step(2);
    pad = 4'b0000;
    step(12);
    check("t2_glitch", bus.button_out, model_word());

    // Red and yellow rise together: red wins, overflow set.
    press(4'b1001, 10);
    poll_read(1, "t3_poll");

    // Five presses into a depth-4 queue.
    press(4'b0001, 9);
    press(4'b0100, 9);
    press(4'b1000, 9);
    press(4'b0010, 9);
    press(4'b0001, 9);
    for (int i = 0; i < 4; i++) poll_read(2, "t4_poll");
    poll_read(1, "t4_empty");

    // Full queue, push lands in the same cycle as the pop strobe.
    press(4'b0001, 9);
    press(4'b0010, 9);
    press(4'b0100, 9);
    press(4'b0001, 9);
    pad      = 4'b1000;
    bus.poll = 1'b1;
    step(6);
    check("t5_pre", bus.button_out, model_word());
    bus.poll = 1'b0;
    step(1);
    void'(q.pop_front());
    q.push_back(2'd3);
    evcnt = evcnt + 16'd1;
    ovf   = 1'b0;
    check("t5_coincide", bus.button_out, model_word());
    pad = 4'b0000;
    step(12);
    for (int i = 0; i < 5; i++) poll_read(1, "t5_drain");

    // Reset mid-poll with red held through release.
    press(4'b0100, 9);
    press(4'b0010, 9);
    pad      = 4'b0001;
    bus.poll = 1'b1;
    step(2);
    reset    = 1'b0;
    bus.poll = 1'b0;
    step(1);
    q.delete();
    ovf   = 1'b0;
    evcnt = '0;
    check("t6_in_reset", bus.button_out, model_word());
    step(1);
    reset = 1'b1;
    step(20);
    check("t6_held", bus.button_out, model_word());
    pad = 4'b0000;
    step(12);
    check("t6_released", bus.button_out, model_word());
    press(4'b0001, 10);
    poll_read(1, "t6_poll");

    // Random presses (mostly single, some simultaneous) interleaved with polls.
    for (int it = 0; it < 30; it++) begin
      logic [3:0] mask;
      if ($urandom_range(0, 9) < 7) mask = 4'b0001 << $urandom_range(0, 3);
      else                          mask = 4'($urandom_range(1, 15));
      press(mask, 9 + $urandom_range(0, 4));
      if ($urandom_range(0, 2) != 0) poll_read($urandom_range(1, 4), "rnd_poll");
    end
    for (int i = 0; i < DEPTH + 1; i++) poll_read(1, "rnd_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
